vdc_timing_gen: RTL and testbench

//  Parametrised VDC raster timing generator, successor to the fixed-width VDC clock generator.

---
 rtl/vdc_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_vdc_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_timing_gen.sv
// vdc_timing_gen: parametrised VDC raster timing generator.
// Produces column/row/character-line counters, sync, blank, blink and
// event strobes for the fetch and pixel pipelines. Supports interlace
// (R8 modes 01/11) with a half-line vsync in the odd field, wrap logic
// that tolerates registers shrinking mid-line, and configurable blink rates.
module vdc_timing_gen #(
  parameter int CW      = 8,
  parameter int LW      = 5,
  parameter int SW      = 13,
  parameter int BLINK_A = 16,
  parameter int BLINK_B = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          enable0,
  input  logic [CW-1:0] reg_ht,
  input  logic [CW-1:0] reg_hd,
  input  logic [CW-1:0] reg_hp,
  input  logic [CW-1:0] reg_vt,
  input  logic [CW-1:0] reg_vd,
  input  logic [CW-1:0] reg_vp,
  input  logic [CW-1:0] reg_deb,
  input  logic [CW-1:0] reg_dee,
  input  logic [3:0]    reg_hw,
  input  logic [3:0]    reg_vw,
  input  logic [LW-1:0] reg_va,
  input  logic [1:0]    reg_im,
  input  logic [LW-1:0] reg_ctv,
  input  logic [3:0]    reg_cth,
  output logic [1:0]    newFrame,
  output logic          newRow,
  output logic          newLine,
  output logic          newCol,
  output logic          endCol,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic [LW-1:0] line,
  output logic          field,
  output logic          hVisible,
  output logic          vVisible,
  output logic [1:0]    blink,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank
);

  // Blink divider sizing; degenerate parameter values collapse to "every frame".
  localparam int BAN = (BLINK_A < 1) ? 1 : BLINK_A;
  localparam int BBN = (BLINK_B < 2) ? 1 : BLINK_B / 2;
  localparam int BAW = (BAN < 2) ? 1 : $clog2(BAN);
  localparam int BBW = (BBN < 2) ? 1 : $clog2(BBN);
  localparam logic [BAW-1:0] BA_LAST = BAW'(BAN - 1);
  localparam logic [BBW-1:0] BB_LAST = BBW'(BBN - 1);

  localparam logic [1:0] IM_INTERLACE_VIDEO = 2'b11;

  logic rst;
  assign rst = reset | init;

  // State registers and their next-state values
  logic          start_q,    start_d;
  logic [3:0]    dot_q,      dot_d;
  logic [CW-1:0] col_q,      col_d;
  logic [CW-1:0] row_q,      row_d;
  logic [LW-1:0] line_q,     line_d;
  logic [SW-1:0] scan_q,     scan_d;
  logic          field_q,    field_d;
  logic [1:0]    im_q,       im_d;
  logic [CW-1:0] hcnt_q,     hcnt_d;
  logic [CW-1:0] vcnt_q,     vcnt_d;
  logic [4:0]    hs_cnt_q,   hs_cnt_d;
  logic [4:0]    vs_cnt_q,   vs_cnt_d;
  logic [4:0]    vb_cnt_q,   vb_cnt_d;
  logic          hdis_q,     hdis_d;
  logic [1:0]    newframe_q, newframe_d;
  logic          newrow_q,   newrow_d;
  logic          newline_q,  newline_d;
  logic          newcol_q,   newcol_d;
  logic          endcol_q,   endcol_d;
  logic          hsync_q,    hsync_d;
  logic          vsync_q,    vsync_d;
  logic          hblank_q,   hblank_d;
  logic          vblank_q,   vblank_d;
  logic [1:0]    blink_q,    blink_d;
  logic [BAW-1:0] bca_q,     bca_d;
  logic [BBW-1:0] bcb_q,     bcb_d;

  // Frame geometry, all in SW-bit arithmetic
  logic [SW-1:0] lines_per_row;
  logic [SW-1:0] vtotal;
  logic [SW-1:0] vend;
  logic [SW-1:0] vs_start;
  logic [SW-1:0] vb_start;
  logic          odd_q;
  logic [4:0]    hs_w;
  logic [4:0]    vs_w;

  assign odd_q         = im_q[0] & field_q;
  assign lines_per_row = SW'(reg_ctv) + SW'(1);
  assign vtotal        = lines_per_row * (SW'(reg_vt) + SW'(1)) + SW'(reg_va);
  // The odd field of an interlaced frame carries one extra scanline.
  assign vend          = vtotal - SW'(1) + SW'(odd_q);
  assign vs_start      = lines_per_row * SW'(reg_vp);
  // vblank leads vsync by two scanlines; a start near the top wraps into the previous frame.
  assign vb_start      = (vs_start >= SW'(2)) ? (vs_start - SW'(2)) : (vend + vs_start - SW'(1));
  assign hs_w          = (reg_hw == 4'd0) ? 5'd16 : {1'b0, reg_hw};
  assign vs_w          = (reg_vw == 4'd0) ? 5'd16 : {1'b0, reg_vw};

  // Event decode for the current dot
  logic          col_enter;
  logic          col_step;
  logic          line_evt;
  logic          frame_end;
  logic [LW:0]   line_sum;
  logic          row_wrap;
  logic [LW-1:0] line_base_q;
  logic          field_nx;
  logic          odd_nx;
  logic [CW-1:0] vs_col;

  assign col_enter   = (dot_q == 4'd0);
  // The first dot after reset opens column 0 instead of advancing past it.
  assign col_step    = col_enter & ~start_q;
  // >= rather than == so a shrunk R0 wraps at the next column instead of running to 2^CW.
  assign line_evt    = col_step & (col_q >= reg_ht);
  assign frame_end   = line_evt & (scan_q >= vend);
  assign line_sum    = {1'b0, line_q} +
                       ((im_q == IM_INTERLACE_VIDEO) ? (LW+1)'(2) : (LW+1)'(1));
  assign row_wrap    = line_sum > {1'b0, reg_ctv};
  assign line_base_q = (im_q == IM_INTERLACE_VIDEO) ? LW'(field_q) : '0;
  assign field_nx    = reg_im[0] ? ~field_q : 1'b0;
  assign odd_nx      = frame_end ? (reg_im[0] & field_nx) : odd_q;
  // Odd-field vsync starts half a line late.
  assign vs_col      = odd_nx ? (reg_ht >> 1) : '0;

  // Next-state computation for all counters, strobes and sync/blank flags
  always_comb begin
    start_d    = 1'b0;
    dot_d      = col_enter ? reg_cth : (dot_q - 4'd1);
    col_d      = col_q;
    row_d      = row_q;
    line_d     = line_q;
    scan_d     = scan_q;
    field_d    = field_q;
    im_d       = im_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hs_cnt_d   = hs_cnt_q;
    vs_cnt_d   = vs_cnt_q;
    vb_cnt_d   = vb_cnt_q;
    hdis_d     = hdis_q;
    newframe_d = 2'b00;
    newrow_d   = 1'b0;
    newline_d  = line_evt;
    newcol_d   = col_enter;
    endcol_d   = (dot_q == 4'd1) | (reg_cth == 4'd0);
    blink_d    = blink_q;
    bca_d      = bca_q;
    bcb_d      = bcb_q;

    if (col_step) begin
      col_d = line_evt ? '0 : (col_q + CW'(1));
    end

    if (frame_end) begin
      scan_d     = '0;
      row_d      = '0;
      im_d       = reg_im;
      field_d    = field_nx;
      line_d     = (reg_im == IM_INTERLACE_VIDEO) ? LW'(field_nx) : '0;
      newrow_d   = 1'b1;
      newframe_d = reg_im[0] ? {~field_nx, field_nx} : 2'b11;
      vcnt_d     = reg_vd;
      if (bca_q == BA_LAST) begin
        bca_d      = '0;
        blink_d[0] = ~blink_q[0];
      end else begin
        bca_d = bca_q + BAW'(1);
      end
      if (bcb_q == BB_LAST) begin
        bcb_d      = '0;
        blink_d[1] = ~blink_q[1];
      end else begin
        bcb_d = bcb_q + BBW'(1);
      end
    end else if (line_evt) begin
      scan_d = scan_q + SW'(1);
      if (row_wrap) begin
        line_d   = line_base_q;
        row_d    = row_q + CW'(1);
        newrow_d = 1'b1;
        if (vcnt_q != '0) vcnt_d = vcnt_q - CW'(1);
      end else begin
        line_d = line_sum[LW-1:0];
      end
    end

    // Vertical display window opens on the first row after reset as well.
    if (start_q) vcnt_d = reg_vd;

    if (col_enter) begin
      if (col_d == reg_hp) hs_cnt_d = hs_w;
      else if (hs_cnt_q != 5'd0) hs_cnt_d = hs_cnt_q - 5'd1;

      // Clear has priority when both edges land on the same column.
      if (col_d == reg_dee) hdis_d = 1'b0;
      else if (col_d == reg_deb) hdis_d = 1'b1;

      if ((col_d == CW'(7)) && (vcnt_q != '0)) hcnt_d = reg_hd;
      else if (hcnt_q != '0) hcnt_d = hcnt_q - CW'(1);

      if (col_d == vs_col) begin
        if (scan_d == vs_start) vs_cnt_d = vs_w;
        else if (vs_cnt_q != 5'd0) vs_cnt_d = vs_cnt_q - 5'd1;
      end

      if (col_d == '0) begin
        if (scan_d == vb_start) vb_cnt_d = vs_w + 5'd4;
        else if (vb_cnt_q != 5'd0) vb_cnt_d = vb_cnt_q - 5'd1;
      end
    end

    // Display-enable start beyond the line total never arrives: keep enabled.
    if (reg_deb > reg_ht) hdis_d = 1'b1;

    hsync_d  = (hs_cnt_d != 5'd0);
    vsync_d  = (vs_cnt_d != 5'd0);
    hblank_d = ~hdis_d | hsync_d;
    vblank_d = (vb_cnt_d != 5'd0);
  end

  // State update: reset/init clears everything, otherwise advance on dot-clock enable
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q    <= 1'b1;
      dot_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      line_q     <= '0;
      scan_q     <= '0;
      field_q    <= 1'b0;
      im_q       <= reg_im;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hs_cnt_q   <= '0;
      vs_cnt_q   <= '0;
      vb_cnt_q   <= '0;
      hdis_q     <= 1'b0;
      newframe_q <= 2'b00;
      newrow_q   <= 1'b0;
      newline_q  <= 1'b0;
      newcol_q   <= 1'b0;
      endcol_q   <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      blink_q    <= 2'b00;
      bca_q      <= '0;
      bcb_q      <= '0;
    end else if (enable0) begin
      start_q    <= start_d;
      dot_q      <= dot_d;
      col_q      <= col_d;
      row_q      <= row_d;
      line_q     <= line_d;
      scan_q     <= scan_d;
      field_q    <= field_d;
      im_q       <= im_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hs_cnt_q   <= hs_cnt_d;
      vs_cnt_q   <= vs_cnt_d;
      vb_cnt_q   <= vb_cnt_d;
      hdis_q     <= hdis_d;
      newframe_q <= newframe_d;
      newrow_q   <= newrow_d;
      newline_q  <= newline_d;
      newcol_q   <= newcol_d;
      endcol_q   <= endcol_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      blink_q    <= blink_d;
      bca_q      <= bca_d;
      bcb_q      <= bcb_d;
    end
  end

  assign newFrame = newframe_q;
  assign newRow   = newrow_q;
  assign newLine  = newline_q;
  assign newCol   = newcol_q;
  assign endCol   = endcol_q;
  assign col      = col_q;
  assign row      = row_q;
  assign line     = line_q;
  assign field    = field_q;
  assign hVisible = (hcnt_q != '0);
  assign vVisible = (vcnt_q != '0);
  assign blink    = blink_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign hblank   = hblank_q;
  assign vblank   = vblank_q;

endmodule

// File: tb/tb_vdc_timing_gen.sv
// Directed testbench for vdc_timing_gen using a compact raster
// (1 dot per column, 10 columns, 2 lines per row, 4 rows) plus
// wider configurations for wrap, interlace and dot-counter cases.
module tb_vdc_timing_gen;

  logic       clk = 1'b0;
  logic       reset, init, enable0;
  logic [7:0] reg_ht, reg_hd, reg_hp, reg_vt, reg_vd, reg_vp, reg_deb, reg_dee;
  logic [3:0] reg_hw, reg_vw, reg_cth;
  logic [4:0] reg_va, reg_ctv;
  logic [1:0] reg_im;

  logic [1:0] newFrame, blink;
  logic       newRow, newLine, newCol, endCol, field, hVisible, vVisible;
  logic       hsync, vsync, hblank, vblank;
  logic [7:0] col, row;
  logic [4:0] line;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;

  logic [63:0] allout;
  assign allout = {28'd0, newFrame, newRow, newLine, newCol, endCol, col, row, line,
                   field, hVisible, vVisible, blink, hsync, vsync, hblank, vblank};

  vdc_timing_gen dut (
    .clk(clk), .reset(reset), .init(init), .enable0(enable0),
    .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hp(reg_hp), .reg_vt(reg_vt),
    .reg_vd(reg_vd), .reg_vp(reg_vp), .reg_deb(reg_deb), .reg_dee(reg_dee),
    .reg_hw(reg_hw), .reg_vw(reg_vw), .reg_va(reg_va), .reg_im(reg_im),
    .reg_ctv(reg_ctv), .reg_cth(reg_cth),
    .newFrame(newFrame), .newRow(newRow), .newLine(newLine), .newCol(newCol),
    .endCol(endCol), .col(col), .row(row), .line(line), .field(field),
    .hVisible(hVisible), .vVisible(vVisible), .blink(blink),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_frame(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (newFrame == 2'b00 && k < 400);
  endtask

  task automatic wait_line(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!newLine && k < 3000);
  endtask

  task automatic cfg_small();
    reg_ht = 8'd9;  reg_hd = 8'd4;  reg_hp = 8'd6;  reg_hw = 4'd2;
    reg_deb = 8'd1; reg_dee = 8'd8; reg_vt = 8'd3;  reg_vd = 8'd2;
    reg_vp = 8'd1;  reg_vw = 4'd1;  reg_va = 5'd0;  reg_im = 2'b00;
    reg_ctv = 5'd1; reg_cth = 4'd0;
  endtask

  initial begin
    enable0 = 1'b1; reset = 1'b1; init = 1'b0;
    cfg_small();
    adv(3);
    chk("reset_all_zero", allout, 64'd0);

    // First enabled cycle opens column 0
    reset = 1'b0;
    tick();
    chk("e1_col", 64'(col), 64'd0);
    chk("e1_newcol", 64'(newCol), 64'd1);
    chk("e1_endcol", 64'(endCol), 64'd1);
    chk("e1_hblank", 64'(hblank), 64'd1);
    chk("e1_vblank", 64'(vblank), 64'd1);
    chk("e1_vvisible", 64'(vVisible), 64'd1);

    // Stall: nothing moves while enable0 is low
    enable0 = 1'b0;
    adv(3);
    chk("stall_col", 64'(col), 64'd0);
    chk("stall_newcol", 64'(newCol), 64'd1);
    enable0 = 1'b1;

    adv(5);
    chk("col5", 64'(col), 64'd5);
    chk("col5_hsync", 64'(hsync), 64'd0);
    chk("col5_hblank", 64'(hblank), 64'd0);
    tick();
    chk("col6_hsync", 64'(hsync), 64'd1);
    chk("col6_hblank", 64'(hblank), 64'd1);
    tick();
    chk("col7_hvis", 64'(hVisible), 64'd1);
    tick();
    chk("col8_hsync", 64'(hsync), 64'd0);
    chk("col8_hblank", 64'(hblank), 64'd1);
    adv(2);
    chk("l1_col", 64'(col), 64'd0);
    chk("l1_newline", 64'(newLine), 64'd1);
    chk("l1_line", 64'(line), 64'd1);
    chk("l1_row", 64'(row), 64'd0);
    chk("l1_hvis", 64'(hVisible), 64'd1);
    chk("l1_vsync", 64'(vsync), 64'd0);
    tick();
    chk("l1c1_hvis", 64'(hVisible), 64'd0);
    chk("l1c1_newline", 64'(newLine), 64'd0);
    adv(9);
    chk("s2_line", 64'(line), 64'd0);
    chk("s2_row", 64'(row), 64'd1);
    chk("s2_newrow", 64'(newRow), 64'd1);
    chk("s2_vsync", 64'(vsync), 64'd1);
    adv(10);
    chk("s3_vsync", 64'(vsync), 64'd0);
    chk("s3_vblank", 64'(vblank), 64'd1);
    adv(10);
    chk("s4_vvisible", 64'(vVisible), 64'd0);
    chk("s4_vblank", 64'(vblank), 64'd1);
    chk("s4_row", 64'(row), 64'd2);
    adv(10);
    chk("s5_vblank", 64'(vblank), 64'd0);
    adv(30);
    chk("f1_newframe", 64'(newFrame), 64'd3);
    chk("f1_row", 64'(row), 64'd0);
    chk("f1_line", 64'(line), 64'd0);
    chk("f1_vvisible", 64'(vVisible), 64'd1);

    wait_frame(n);
    chk("prog_period", 64'(n), 64'd80);
    chk("prog_code", 64'(newFrame), 64'd3);

    // Interlace mode 01 takes effect at the next frame end
    reg_im = 2'b01;
    wait_frame(n);
    chk("im01_switch_period", 64'(n), 64'd80);
    chk("im01_odd_code", 64'(newFrame), 64'd1);
    chk("im01_odd_field", 64'(field), 64'd1);
    adv(23);
    chk("odd_vs_col3", 64'(vsync), 64'd0);
    tick();
    chk("odd_vs_col4_col", 64'(col), 64'd4);
    chk("odd_vs_col4", 64'(vsync), 64'd1);
    adv(9);
    chk("odd_vs_hold", 64'(vsync), 64'd1);
    tick();
    chk("odd_vs_end", 64'(vsync), 64'd0);
    wait_frame(n);
    chk("odd_len_rest", 64'(n), 64'd56);
    chk("even_code", 64'(newFrame), 64'd2);
    wait_frame(n);
    chk("even_len", 64'(n), 64'd80);
    chk("odd_code2", 64'(newFrame), 64'd1);

    // Interlace video mode 11 with 8 scanlines per character row
    reg_ctv = 5'd7; reg_vt = 8'd1; reg_im = 2'b11;
    wait_frame(n);
    chk("im11_odd_len", 64'(n), 64'd170);
    chk("im11_even_code", 64'(newFrame), 64'd2);
    chk("im11_even_line0", 64'(line), 64'd0);
    adv(10);
    chk("im11_even_line2", 64'(line), 64'd2);
    adv(10);
    chk("im11_even_line4", 64'(line), 64'd4);
    adv(10);
    chk("im11_even_line6", 64'(line), 64'd6);
    chk("im11_even_norow", 64'(newRow), 64'd0);
    adv(10);
    chk("im11_even_wrap", 64'(line), 64'd0);
    chk("im11_even_row", 64'(row), 64'd1);
    chk("im11_even_newrow", 64'(newRow), 64'd1);
    wait_frame(n);
    chk("im11_even_len_rest", 64'(n), 64'd120);
    chk("im11_odd_code", 64'(newFrame), 64'd1);
    chk("im11_odd_line1", 64'(line), 64'd1);
    adv(10);
    chk("im11_odd_line3", 64'(line), 64'd3);
    adv(20);
    chk("im11_odd_line7", 64'(line), 64'd7);
    adv(10);
    chk("im11_odd_wrap", 64'(line), 64'd1);
    chk("im11_odd_row", 64'(row), 64'd1);
    chk("im11_odd_newrow", 64'(newRow), 64'd1);

    // Re-init with a wide line, then shrink R0 mid-line
    init = 1'b1;
    cfg_small();
    reg_ht = 8'd126; reg_hp = 8'd120; reg_hw = 4'd0;
    tick();
    chk("init_all_zero", allout, 64'd0);
    init = 1'b0;
    tick();
    adv(80);
    chk("run_col80", 64'(col), 64'd80);
    reg_ht = 8'd50;
    tick();
    chk("run_wrap_col", 64'(col), 64'd0);
    chk("run_wrap_newline", 64'(newLine), 64'd1);
    tick();
    chk("run_col1", 64'(col), 64'd1);
    chk("run_newline_clr", 64'(newLine), 64'd0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (newLine) cnt++;
    end
    chk("run_newline_count", 64'(cnt), 64'd1);
    chk("run_col_back0", 64'(col), 64'd0);

    // hsync of 16 columns starting at col 120 wraps into the next line
    reg_ht = 8'd126;
    adv(127);
    chk("hs_wrap_col0", 64'(col), 64'd0);
    chk("hs_wrap_at0", 64'(hsync), 64'd1);
    adv(8);
    chk("hs_wrap_col8", 64'(hsync), 64'd1);
    tick();
    chk("hs_wrap_col9", 64'(hsync), 64'd0);
    cnt = 0;
    for (int i = 0; i < 127; i++) begin
      tick();
      if (hsync) cnt++;
    end
    chk("hs_width16", 64'(cnt), 64'd16);

    // 8 dots per column: 127 columns give 1016 cycles per line
    reg_cth = 4'd7;
    wait_line(n);
    wait_line(n);
    chk("dot_line_period", 64'(n), 64'd1016);
    chk("dot_newcol_at_line", 64'(newCol), 64'd1);
    chk("dot_endcol_at_line", 64'(endCol), 64'd0);
    adv(7);
    chk("dot_endcol_last", 64'(endCol), 64'd1);
    chk("dot_newcol_last", 64'(newCol), 64'd0);
    tick();
    chk("dot_newcol_next", 64'(newCol), 64'd1);
    chk("dot_endcol_next", 64'(endCol), 64'd0);

    // Reset mid-frame, then blink over 32 frames of 80 cycles
    reset = 1'b1;
    cfg_small();
    tick();
    chk("reset2_all_zero", allout, 64'd0);
    reset = 1'b0;
    tick();
    adv(1199);
    chk("blink_e1200", 64'(blink), 64'd0);
    tick();
    chk("blink_b1_15fr", 64'(blink), 64'd2);
    adv(79);
    chk("blink_e1280", 64'(blink), 64'd2);
    tick();
    chk("blink_a_16fr", 64'(blink), 64'd3);
    adv(1279);
    chk("blink_e2560", 64'(blink), 64'd1);
    tick();
    chk("blink_a_32fr", 64'(blink), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
